// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared opcodes, FSM encoding and instruction field positions
package seq_pkg;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_EMIT = 2'd2
    } seq_state_e;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 2;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/reg_bank4.sv
// rtl/reg_bank4.sv - four-entry register bank, one sync write port, two comb read ports
module reg_bank4 #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        raddr_a_i,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] reg0_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [DATA_W-1:0] reg3_o
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign reg0_o    = regs_q[0];
    assign reg1_o    = regs_q[1];
    assign reg2_o    = regs_q[2];
    assign reg3_o    = regs_q[3];

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - instruction-driven register bank feeding a 4:1 output mux
module operand_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr,
    output logic [DATA_W-1:0] reg0,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] reg3,
    output logic [1:0]        select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              carry
);

    seq_state_e        state_q;
    logic [7:0]        instr_q;
    logic [1:0]        select_q;
    logic              out_valid_q;
    logic              carry_q;

    logic [1:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W:0]   sum;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign op      = instr_q[OPC_HI:OPC_LO];
    assign rd      = instr_q[RD_HI:RD_LO];
    assign rs      = instr_q[RS_HI:RS_LO];
    assign imm_ext = DATA_W'(instr_q[IMM_HI:IMM_LO]);
    assign sum     = {1'b0, rd_val} + {1'b0, rs_val};

    reg_bank4 #(.DATA_W(DATA_W)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rd),
        .raddr_b_i (rs),
        .rdata_a_o (rd_val),
        .rdata_b_o (rs_val),
        .reg0_o    (reg0),
        .reg1_o    (reg1),
        .reg2_o    (reg2),
        .reg3_o    (reg3)
    );

    // Register writes happen only on the EXEC edge; OUT never writes the bank.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        if (state_q == ST_EXEC) begin
            case (op)
                OP_LDI: begin rf_we = 1'b1; rf_wdata = imm_ext;          end
                OP_MOV: begin rf_we = 1'b1; rf_wdata = rs_val;           end
                OP_ADD: begin rf_we = 1'b1; rf_wdata = sum[DATA_W-1:0];  end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            select_q    <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op == OP_ADD) begin
                        carry_q <= sum[DATA_W];
                    end
                    if (op == OP_OUT) begin
                        select_q    <= rs;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign select      = select_q;
    assign out_valid   = out_valid_q;
    assign carry       = carry_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - randomized and directed bench against a transaction-level model
module tb_operand_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [7:0]   instr;
    logic [W-1:0] reg0, reg1, reg2, reg3;
    logic [1:0]   select;
    logic         out_valid;
    logic         out_ready;
    logic         carry;

    operand_sequencer #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .reg0        (reg0),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3),
        .select      (select),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .carry       (carry)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: architectural registers plus at most one accepted-but-unexecuted instruction.
    logic [W-1:0] m_reg [4];
    logic         m_carry;
    logic [1:0]   m_sel;
    logic         m_emit;
    logic [7:0]   m_pend [$];
    int           m_accepted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_ready();
        return (m_pend.size() == 0) && !m_emit;
    endfunction

    function automatic logic [7:0] enc(input logic [1:0] op, input logic [1:0] rd, input logic [3:0] lo);
        return {op, rd, lo};
    endfunction

    task automatic m_execute(input logic [7:0] x);
        int s;
        case (x[7:6])
            2'd0: m_reg[x[5:4]] = x[3:0];
            2'd1: m_reg[x[5:4]] = m_reg[x[3:2]];
            2'd2: begin
                s = int'(m_reg[x[5:4]]) + int'(m_reg[x[3:2]]);
                m_reg[x[5:4]] = s[W-1:0];
                m_carry = (s >= (1 << W));
            end
            default: begin
                m_sel  = x[3:2];
                m_emit = 1'b1;
            end
        endcase
    endtask

    task automatic m_edge(input logic r, input logic v, input logic [7:0] ins, input logic ordy);
        if (r) begin
            for (int i = 0; i < 4; i++) m_reg[i] = '0;
            m_carry = 1'b0;
            m_sel   = 2'd0;
            m_emit  = 1'b0;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_execute(m_pend.pop_front());
        end else if (m_emit) begin
            if (ordy) m_emit = 1'b0;
        end else if (v) begin
            m_pend.push_back(ins);
            m_accepted++;
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return 32'({reg3, reg2, reg1, reg0, select, out_valid, carry, instr_ready});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({m_reg[3], m_reg[2], m_reg[1], m_reg[0], m_sel, m_emit, m_carry, m_ready()});
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [7:0] ins, input logic ordy);
        rst = r; instr_valid = v; instr = ins; out_ready = ordy;
        @(posedge clk);
        m_edge(r, v, ins, ordy);
        @(negedge clk);
        chk("cycle", obs_vec(), exp_vec());
    endtask

    task automatic issue(input logic [7:0] ins);
        cyc(1'b0, 1'b1, ins, 1'b0);
        chk("exec_ready_low", 32'(instr_ready), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ready_back", 32'(instr_ready), 32'd1);
    endtask

    initial begin
        int budget;
        m_accepted = 0;
        rst = 1'b1; instr_valid = 1'b0; instr = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("reset_state", obs_vec(), 32'h1);

        issue(enc(2'd0, 2'd0, 4'd3));
        issue(enc(2'd0, 2'd1, 4'd5));
        issue(enc(2'd0, 2'd2, 4'd9));
        issue(enc(2'd0, 2'd3, 4'd15));
        chk("ldi_regs", 32'({reg3, reg2, reg1, reg0, carry}), 32'({4'd15, 4'd9, 4'd5, 4'd3, 1'b0}));

        issue(enc(2'd2, 2'd3, {2'd2, 2'd0}));
        chk("add_wrap", 32'({reg3, carry}), 32'({4'd8, 1'b1}));
        issue(enc(2'd2, 2'd0, {2'd0, 2'd0}));
        chk("add_double", 32'({reg0, carry}), 32'({4'd6, 1'b0}));
        issue(enc(2'd1, 2'd1, {2'd3, 2'd0}));
        chk("mov", 32'({reg1, carry}), 32'({4'd8, 1'b0}));

        // OUT r2 with a stalled consumer while upstream keeps offering an LDI.
        cyc(1'b0, 1'b1, enc(2'd3, 2'd0, {2'd2, 2'd0}), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, enc(2'd0, 2'd0, 4'd1), 1'b0);
            chk("emit_hold", 32'({select, out_valid, instr_ready}), 32'({2'd2, 1'b1, 1'b0}));
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("emit_done", 32'({out_valid, instr_ready, reg0}), 32'({1'b0, 1'b1, 4'd6}));

        cyc(1'b0, 1'b1, enc(2'd3, 2'd0, {2'd1, 2'd0}), 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("out_fast_valid", 32'({select, out_valid}), 32'({2'd1, 1'b1}));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("out_fast_after", 32'({select, out_valid, instr_ready}), 32'({2'd1, 1'b0, 1'b1}));

        cyc(1'b0, 1'b1, enc(2'd0, 2'd0, 4'd7), 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_in_exec", obs_vec(), 32'h1);

        issue(enc(2'd0, 2'd2, 4'd5));
        issue(enc(2'd2, 2'd2, {2'd2, 2'd0}));
        cyc(1'b0, 1'b1, enc(2'd3, 2'd0, {2'd3, 2'd0}), 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("emit_before_rst", 32'({select, out_valid, reg2}), 32'({2'd3, 1'b1, 4'd10}));
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_in_emit", obs_vec(), 32'h1);

        m_accepted = 0;
        budget = 20000;
        while (m_accepted < 1000 && budget > 0) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                8'($urandom), 1'($urandom_range(0, 1)));
            budget--;
        end
        chk("random_accepted", 32'(m_accepted >= 1000), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Four-entry register bank with an instruction-driven control FSM. It sits directly upstream of the 4:1 4-bit output multiplexer: it drives the mux data inputs (`reg0`..`reg3` → `in0`..`in3`) and its `select`, and signals when the mux output is valid. It accepts one 8-bit instruction at a time over a valid/ready handshake and executes load, move, add or output operations.

## Interface
- `DATA_W`, default 4: register and datapath width; must equal the mux width. The immediate is zero-extended when `DATA_W` > 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  an instruction is present on `instr`.
- `instr_ready`  out  1  the block can accept an instruction this cycle.
- `instr`  in  8  instruction: [7:6] opcode, [5:4] rd, [3:2] rs, [3:0] imm.
- `reg0`..`reg3`  out  DATA_W each  register contents; these feed mux `in0`..`in3`.
- `select`  out  2  mux select.
- `out_valid`  out  1  the mux output (selected register) is valid for the consumer.
- `out_ready`  in  1  the consumer takes the mux output.
- `carry`  out  1  carry flag from the last ADD.

## Operation
- Opcodes:
  - 00 LDI: reg[rd] = imm.
  - 01 MOV: reg[rd] = reg[rs].
  - 10 ADD: {carry, reg[rd]} = reg[rd] + reg[rs]. The sum wraps mod 2^DATA_W; carry is bit DATA_W.
  - 11 OUT: select = rs, then present through the output handshake. The rd field is ignored.
- FSM states: IDLE, EXEC, EMIT. Encoding: 2 bits, IDLE = 0.
  - IDLE: `instr_ready` = 1. If `instr_valid` is high, capture `instr` into `instr_q` and go to EXEC.
  - EXEC: `instr_ready` = 0. Perform the operation on `instr_q`. Non-OUT opcodes go to IDLE. OUT loads `select`, sets `out_valid` and goes to EMIT.
  - EMIT: `instr_ready` = 0 and `out_valid` = 1. When `out_ready` = 1, clear `out_valid` and go to IDLE. Otherwise hold.
- Operand reads use register values as they stand in EXEC.
  - ADD with rd == rs doubles the register.
  - MOV with rd == rs is a no-op write.
- `carry` changes only on ADD. LDI, MOV and OUT preserve it.
- `select` retains its last value after EMIT, so the mux output stays stable. Registers are only written in EXEC.
- Reset, from any state including mid-EXEC or mid-EMIT:
  - state returns to IDLE;
  - all registers, `select` and `carry` are cleared to 0, and `out_valid` to 0;
  - any in-flight instruction is discarded.
- Reset values after `rst`: `instr_ready` = 1, `reg0`..`reg3` = 0, `select` = 0, `out_valid` = 0, `carry` = 0.

## Timing
- Instruction accepted at edge E0 (`instr_valid` && `instr_ready`).
- Cycle after E0: EXEC, with `instr_ready` low.
- At edge E1:
  - the register or carry write becomes visible;
  - for non-OUT, `instr_ready` returns high in the following cycle.
- Non-OUT throughput: one instruction per 2 cycles.
- OUT: `select` and `out_valid` become visible after E1. Minimum EMIT length is 1 cycle, when `out_ready` is already high. `instr_ready` returns one cycle after the handshake edge.
- `out_valid` never drops without `out_ready`. `select` is stable while `out_valid` = 1.
- `instr_valid` while `instr_ready` = 0: the instruction is not taken. The upstream holds it.
- `rst` is sampled at the edge and has priority over all other inputs in the same cycle.

## Structure
- Shared package `seq_pkg`:
  - opcode localparams (OP_LDI, OP_MOV, OP_ADD, OP_OUT);
  - state encoding (ST_IDLE, ST_EXEC, ST_EMIT);
  - instruction field bit positions.
- One sub-module, `reg_bank4`: four DATA_W registers, one synchronous write port (we, waddr, wdata), two combinational read ports and synchronous clear.
- The top level holds the FSM, `instr_q`, the adder/carry, and the `select`/`out_valid` registers.

## Test plan
- Reset, then LDI r0,3; LDI r1,5; LDI r2,9; LDI r3,15, one every 2 cycles → `reg0..3` = 3, 5, 9, 15; `carry` = 0; `instr_ready` toggles 1,0 per instruction.
- ADD r3,r2 (15 + 9) → `reg3` = 8, `carry` = 1. Then ADD r0,r0 (3 + 3) → `reg0` = 6, `carry` = 0. Then MOV r1,r3 → `reg1` = 8, `carry` unchanged at 0.
- OUT r2 with `out_ready` held low for 4 cycles:
  - `select` = 2 and `out_valid` = 1 stay stable for all 4 cycles;
  - `instr_ready` stays 0 and a new `instr_valid` is not accepted;
  - `out_ready` high → `out_valid` drops on the next edge and `instr_ready` = 1 one cycle later.
- OUT r1 with `out_ready` tied high → `out_valid` high for exactly 1 cycle; `select` stays 1 afterwards.
- Assert `rst` during EMIT, and separately during EXEC of LDI r0,7 → next cycle all regs = 0, `select` = 0, `out_valid` = 0, `carry` = 0, `instr_ready` = 1; `reg0` ≠ 7.
- Back-to-back `instr_valid` held high with a changing `instr` → only the instructions presented while `instr_ready` = 1 execute; order preserved; a scoreboard against a reference model matches over 1000 random instructions.
